// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding and default width.
// Imported by serial_subtract_ctrl.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtract.sv
// Existing 1-bit full subtractor cell: d = a - b - bin, bout set when the bit position borrows.
module full_subtract (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: diff = a - b - bin, LSB first through one full_subtract.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtract_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-2:0]   res_sh;
    logic [CNT_W-1:0]   count;
    logic               borrow;
    logic               cell_d;
    logic               cell_bout;
    logic               accept;
    logic               last_bit;

    assign accept   = start && (state != S_RUN);
    assign last_bit = (state == S_RUN) && (count == LAST);
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    full_subtract u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (count == LAST) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand/result shifting; result register stays separate so diff is stable during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            count  <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            count  <= '0;
            borrow <= bin;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= (WIDTH-1)'({cell_d, res_sh} >> 1);
            borrow <= cell_bout;
            if (count != LAST) begin
                count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
        end else if (last_bit) begin
            diff <= {cell_d, res_sh};
            bout <= cell_bout;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    // Operand sign bits are kept from capture time; overflow is judged with the final diff MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (last_bit) begin
                ovf <= (a_msb != b_msb) && (cell_d != a_msb);
            end
        end
    end
`endif

endmodule
